// File: rtl/hs_math_basic_pkg.sv
// Small elaboration-time math helpers shared by the hs_* blocks.
package hs_math_basic_pkg;

    function automatic int unsigned ceil_to_nxt_pow2(input int unsigned x);
        int unsigned p;
        p = 1;
        while (p < x) p = p << 1;
        return p;
    endfunction

endpackage

// File: rtl/hs_mem_pkg.sv
// Shared types and helpers for the hs_mem storage primitives.
package hs_mem_pkg;

    typedef enum logic {HS_MEM_RDW_NEW, HS_MEM_RDW_OLD} hs_mem_rdw_e;

    typedef enum logic {HS_MEM_CLR_IDLE, HS_MEM_CLR_CLEAR} hs_mem_clr_state_e;

    // Widest word the merge helper handles; callers size-cast in and out.
    localparam int HS_MEM_MAX_W = 1024;

    function automatic logic [HS_MEM_MAX_W-1:0] lane_merge(
        input logic [HS_MEM_MAX_W-1:0] old_w,
        input logic [HS_MEM_MAX_W-1:0] new_w,
        input logic [HS_MEM_MAX_W-1:0] ben_mask
    );
        return (old_w & ~ben_mask) | (new_w & ben_mask);
    endfunction

endpackage

// File: rtl/hs_mem_clear_fsm.sv
// Post-reset array initialiser: walks every address once, then hands the
// write port back to the user.
module hs_mem_clear_fsm
    import hs_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH_REAL = 16,
    parameter bit CLEAR_EN   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  init_busy,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(DEPTH_REAL - 1);
    localparam hs_mem_clr_state_e     RESET_STATE = CLEAR_EN ? HS_MEM_CLR_CLEAR : HS_MEM_CLR_IDLE;

    hs_mem_clr_state_e     state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RESET_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        case (state_q)
            HS_MEM_CLR_CLEAR: begin
                clr_we = 1'b1;
                cnt_d  = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == LAST_ADDR) state_d = HS_MEM_CLR_IDLE;
            end
            default: ;
        endcase
    end

    assign init_busy = (state_q == HS_MEM_CLR_CLEAR);
    assign clr_addr  = cnt_q;

endmodule

// File: rtl/hs_mem_sdpram_cfg.sv
// Simple dual-port RAM (one write, one read port, one clock) with byte-lane
// writes, 0/1/2-cycle read latency, selectable read-during-write and self-clear.
module hs_mem_sdpram_cfg
    import hs_mem_pkg::*;
    import hs_math_basic_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    LANE_WIDTH  = 8,
    parameter int                    DATA_DEPTH  = 16,
    parameter int                    RD_LATENCY  = 1,
    parameter hs_mem_rdw_e           RDW_MODE    = HS_MEM_RDW_NEW,
    parameter bit                    CLEAR_EN    = 1'b1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
    localparam int                   LANES       = DATA_WIDTH / LANE_WIDTH,
    localparam int                   ADDR_WIDTH  = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  init_busy,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [LANES-1:0]      wben,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] raddr,
    input  logic                  ren,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid
);

    // A single-word configuration still carries a 1-bit address, so it gets two words.
    localparam int DEPTH_REAL = (DATA_DEPTH > 1) ? int'(ceil_to_nxt_pow2(DATA_DEPTH)) : 2;

    if (DATA_WIDTH % LANE_WIDTH != 0) begin : g_err_lane
        $error("DATA_WIDTH must be a multiple of LANE_WIDTH");
    end
    if (RD_LATENCY < 0 || RD_LATENCY > 2) begin : g_err_lat
        $error("RD_LATENCY must be 0, 1 or 2");
    end
    if (DATA_DEPTH < 1) begin : g_err_depth
        $error("DATA_DEPTH must be at least 1");
    end
    if (DATA_WIDTH > HS_MEM_MAX_W) begin : g_err_width
        $error("DATA_WIDTH exceeds HS_MEM_MAX_W");
    end

    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;

    hs_mem_clear_fsm #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH_REAL (DEPTH_REAL),
        .CLEAR_EN   (CLEAR_EN)
    ) u_clear_fsm (
        .clk       (clk),
        .rst       (rst),
        .init_busy (init_busy),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr)
    );

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [LANES-1:0]      mem_ben;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH_REAL];

    // The clear sequence owns the write port for as long as init_busy is high.
    always_comb begin
        mem_we    = wen;
        mem_addr  = waddr;
        mem_wdata = wdata;
        mem_ben   = wben;
        if (init_busy) begin
            mem_we    = clr_we;
            mem_addr  = clr_addr;
            mem_wdata = CLEAR_VALUE;
            mem_ben   = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < LANES; i++) begin
                if (mem_ben[i]) mem_q[mem_addr][i*LANE_WIDTH +: LANE_WIDTH] <= mem_wdata[i*LANE_WIDTH +: LANE_WIDTH];
            end
        end
    end

    logic                  rd_acc;
    logic                  rd_hit;
    logic [DATA_WIDTH-1:0] rd_old;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] wmask;

    always_comb begin
        wmask = '0;
        for (int i = 0; i < LANES; i++) wmask[i*LANE_WIDTH +: LANE_WIDTH] = {LANE_WIDTH{wben[i]}};
    end

    assign rd_acc = ren & ~init_busy;
    assign rd_hit = wen & ~init_busy & (waddr == raddr);
    assign rd_old = mem_q[raddr];

    // NEW mode forwards the enabled write lanes over the stored word.
    always_comb begin
        rd_word = rd_old;
        if (RDW_MODE == HS_MEM_RDW_NEW && rd_hit) begin
            rd_word = DATA_WIDTH'(lane_merge(HS_MEM_MAX_W'(rd_old), HS_MEM_MAX_W'(wdata), HS_MEM_MAX_W'(wmask)));
        end
    end

    if (RD_LATENCY == 0) begin : g_lat0
        assign rdata  = rd_word;
        assign rvalid = rd_acc;
    end else begin : g_lat_reg
        logic [DATA_WIDTH-1:0] s1_data_q;
        logic                  s1_valid_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1_data_q  <= '0;
                s1_valid_q <= 1'b0;
            end else begin
                s1_valid_q <= rd_acc;
                if (rd_acc) s1_data_q <= rd_word;
            end
        end

        if (RD_LATENCY == 1) begin : g_lat1
            assign rdata  = s1_data_q;
            assign rvalid = s1_valid_q;
        end else begin : g_lat2
            logic [DATA_WIDTH-1:0] s2_data_q;
            logic                  s2_valid_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s2_data_q  <= '0;
                    s2_valid_q <= 1'b0;
                end else begin
                    s2_valid_q <= s1_valid_q;
                    if (s1_valid_q) s2_data_q <= s1_data_q;
                end
            end

            assign rdata  = s2_data_q;
            assign rvalid = s2_valid_q;
        end
    end

endmodule

// File: doc/hs_mem_sdpram_cfg.md
Name: hs_mem_sdpram_cfg

Overview:
- Parametrised simple dual-port RAM: 1 write port, 1 read port, one clock. Next generation of the single-port asynchronous-read RAM.
- Adds per-lane byte-enable writes, a selectable read latency (0/1/2), a selectable read-during-write mode, and a self-clearing FSM that initialises the array after reset.
- Used as the storage primitive under FIFOs, register files and line buffers.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of LANE_WIDTH.
- LANE_WIDTH, 8, width of one write-enable lane; LANES = DATA_WIDTH/LANE_WIDTH.
- DATA_DEPTH, 16, number of words (1-1048576); storage is rounded up to DEPTH_REAL = next power of 2.
- RD_LATENCY, 1, read latency in cycles; legal values 0, 1, 2.
- RDW_MODE, HS_MEM_RDW_NEW, same-address read-during-write result (HS_MEM_RDW_NEW or HS_MEM_RDW_OLD).
- CLEAR_EN, 1, 1 = clear the array after reset; 0 = contents undefined after reset.
- CLEAR_VALUE, '0, DATA_WIDTH-bit word written to every location during the clear.
- ADDR_WIDTH, $clog2(DATA_DEPTH), local parameter; not user-overridable.

Ports:
- clk  input  1  clock; every state change happens on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- init_busy  output  1  high while the clear sequence runs; both ports are ignored while it is high.
- waddr  input  ADDR_WIDTH  write address.
- wdata  input  DATA_WIDTH  write data.
- wben  input  LANES  per-lane write enable; bit i controls wdata[i*LANE_WIDTH +: LANE_WIDTH].
- wen  input  1  write strobe.
- raddr  input  ADDR_WIDTH  read address.
- ren  input  1  read strobe.
- rdata  output  DATA_WIDTH  read data.
- rvalid  output  1  rdata is valid for the read issued RD_LATENCY cycles earlier.

Behaviour:
- Reset values: init_busy = CLEAR_EN; rvalid = 0; all rdata pipeline registers = 0. Array contents are not reset directly.
- Clear FSM, states IDLE and CLEAR:
  - rst asserted -> CLEAR if CLEAR_EN, otherwise IDLE; the clear counter is set to 0.
  - In CLEAR: each cycle, write CLEAR_VALUE (all lanes) to array[cnt], then cnt++.
  - When cnt reaches DEPTH_REAL-1, that write completes and the FSM moves to IDLE; init_busy drops on the following edge.
  - Clear duration: exactly DEPTH_REAL cycles after rst deassertion.
  - rst asserted mid-clear: restart from address 0.
- Write: on an edge where wen & ~init_busy, each lane i with wben[i]=1 is updated; lanes with wben[i]=0 keep their value. wben = 0 is a legal no-op.
- Read, RD_LATENCY = 0:
  - rdata = array[raddr] combinationally.
  - rvalid = ren & ~init_busy combinationally.
- Read, RD_LATENCY = 1: rdata and rvalid are registered on the edge where ren & ~init_busy is sampled.
- Read, RD_LATENCY = 2: one further output register stage; rvalid follows the same pipeline.
- Latency >= 1: rdata holds its last value when no read completes; rvalid pulses for one cycle per accepted read.
- Read-during-write, same address in the same cycle:
  - NEW: the result is a per-lane merge — enabled lanes from wdata, other lanes from old contents. At latency 0 this merge is a combinational forward.
  - OLD: the result is the contents before the write.
  - Different addresses: no interaction between the ports.
- Reads are ignored while init_busy is high: no rvalid is produced.
- Addresses in DATA_DEPTH..DEPTH_REAL-1 are accessible storage; no error is flagged.
- Back-to-back reads at full throughput, one per cycle; no backpressure.
- Elaboration errors (assertions): DATA_WIDTH % LANE_WIDTH != 0; RD_LATENCY not in {0,1,2}; DATA_DEPTH < 1.

Decomposition:
- hs_mem_pkg holds typedef enum hs_mem_rdw_e {HS_MEM_RDW_NEW, HS_MEM_RDW_OLD} and the helper function lane_merge(old, new, ben).
- ceil_to_nxt_pow2 comes from hs_math_basic_pkg.
- One sub-module, hs_mem_clear_fsm: clear counter, state and init_busy, with outputs clr_we / clr_addr. The RAM muxes these outputs onto its write port while init_busy is high.

Test Plan:
- Reset clear: DEPTH=16, CLEAR_VALUE=32'hDEAD_BEEF. Release rst -> init_busy high for exactly 16 cycles; reads of 0..15 then return 32'hDEAD_BEEF.
- Byte enables, latency 1: write addr 3 = 32'h1122_3344 with wben=4'hF, then 32'hAABB_CCDD with wben=4'b0101 -> read addr 3 returns 32'h11BB_33DD one cycle later, with rvalid=1.
- Read-during-write: addr 5 holds 32'h0; same-cycle write 32'hFFFF_FFFF (wben=4'b0011) and read addr 5. NEW -> 32'h0000_FFFF; OLD -> 32'h0000_0000.
- Latency sweep 0/1/2: ren pulses on cycles 10, 11, 13 -> rvalid pulses on cycles 10/11/13, 11/12/14 and 12/13/15 respectively; rdata matches expected data on each pulse.
- Reset mid-clear: assert rst at clear cycle 7 for 1 cycle -> clear restarts from 0 and init_busy stays high for a further 16 cycles. Writes issued during busy (addr 2 = 32'h1234_5678) are dropped; addr 2 reads CLEAR_VALUE.
- Non-pow2 depth: DATA_DEPTH=10 -> clear lasts 16 cycles; write/read at addr 12 round-trips 32'hCAFE_0012.
